// File: rtl/msg_pkg.sv
// Shared message constants for the keyboard-to-UART message path.
package msg_pkg;

  localparam int unsigned DIGITS   = 8;
  localparam int unsigned MSG_LEN  = 10;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;

endpackage

// File: rtl/bit_reverse_message_rom.sv
// Message ROM: typed digits in reverse order, then LF and CR, zero elsewhere.
// One combinational mux feeding a single registered output byte.
module bit_reverse_message_rom
  import msg_pkg::*;
#(
  parameter int unsigned DIGITS  = msg_pkg::DIGITS,
  parameter int unsigned MSG_LEN = msg_pkg::MSG_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            addr,
  input  logic [8*DIGITS-1:0]   bits_in,
  output logic [7:0]            data
);

  localparam int unsigned ADDR_SPACE = 16;

  // Message must be digits + LF + CR and fit the 4-bit address space.
  if (MSG_LEN != DIGITS + 2 || MSG_LEN > ADDR_SPACE) begin : g_bad_len
    $error("bit_reverse_message_rom: MSG_LEN must equal DIGITS+2 and be <= 16");
  end

  logic [7:0] next_data_c;

  // Address 0 maps to the last typed byte so the string prints reversed.
  always_comb begin
    next_data_c = 8'h00;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (32'(addr) == k) begin
        next_data_c = bits_in[8*(DIGITS-1-k) +: 8];
      end
    end
    if (32'(addr) == DIGITS) begin
      next_data_c = ASCII_LF;
    end
    if (32'(addr) == DIGITS + 1) begin
      next_data_c = ASCII_CR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= 8'h00;
    end else begin
      data <= next_data_c;
    end
  end

endmodule

// File: tb/tb_bit_reverse_message_rom.sv
// Directed bench for bit_reverse_message_rom with hand-computed expectations.
module tb_bit_reverse_message_rom;

  logic        clk;
  logic        rst;
  logic [3:0]  addr;
  logic [63:0] bits_in;
  logic [7:0]  data;

  int total;
  int bad;

  bit_reverse_message_rom dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .bits_in (bits_in),
    .data    (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte k of the result is character k of the typed string.
  function automatic logic [63:0] typed(input string s);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = s[k];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = 4'd8; bits_in = typed("12345678");
    step();
    total++;
    if (data !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%h want=00", data);
    end
    rst = 1'b0;
    step();
    total++;
    if (data !== 8'h0A) begin
      bad++; $display("FAIL post_reset_lf got=%h want=0a", data);
    end
  endtask

  task automatic test_reversal();
    logic [7:0] exp_v [10] = '{8'h31, 8'h30, 8'h30, 8'h30, 8'h30,
                               8'h30, 8'h30, 8'h30, 8'h0A, 8'h0D};
    bits_in = typed("00000001");
    for (int a = 0; a < 10; a++) begin
      addr = 4'(a);
      step();
      total++;
      if (data !== exp_v[a]) begin
        bad++; $display("FAIL reversal addr=%0d got=%h want=%h", a, data, exp_v[a]);
      end
    end
  endtask

  task automatic test_mixed();
    logic [7:0] exp_v [8] = '{8'h30, 8'h31, 8'h30, 8'h30,
                              8'h31, 8'h30, 8'h31, 8'h31};
    bits_in = typed("11010010");
    for (int a = 0; a < 8; a++) begin
      addr = 4'(a);
      step();
      total++;
      if (data !== exp_v[a]) begin
        bad++; $display("FAIL mixed addr=%0d got=%h want=%h", a, data, exp_v[a]);
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int a = 10; a < 16; a++) begin
      addr = 4'(a);
      bits_in = {$urandom, $urandom};
      step();
      total++;
      if (data !== 8'h00) begin
        bad++; $display("FAIL oor addr=%0d got=%h want=00", a, data);
      end
    end
  endtask

  task automatic test_live_update();
    bits_in = typed("00000000");
    addr = 4'd0;
    step();
    total++;
    if (data !== 8'h30) begin
      bad++; $display("FAIL live_before got=%h want=30", data);
    end
    bits_in[63:56] = 8'h31;
    step();
    total++;
    if (data !== 8'h31) begin
      bad++; $display("FAIL live_after got=%h want=31", data);
    end
    // Unfilled slot passes through as zero.
    bits_in[63:56] = 8'h00;
    step();
    total++;
    if (data !== 8'h00) begin
      bad++; $display("FAIL live_empty got=%h want=00", data);
    end
  endtask

  task automatic test_mid_reset();
    bits_in = typed("12345678");
    addr = 4'd3;
    step();
    total++;
    if (data !== 8'h35) begin
      bad++; $display("FAIL mid_pre addr=3 got=%h want=35", data);
    end
    addr = 4'd4; rst = 1'b1;
    step();
    total++;
    if (data !== 8'h00) begin
      bad++; $display("FAIL mid_rst got=%h want=00", data);
    end
    rst = 1'b0;
    step();
    total++;
    if (data !== 8'h34) begin
      bad++; $display("FAIL mid_resume addr=4 got=%h want=34", data);
    end
    addr = 4'd9;
    step();
    total++;
    if (data !== 8'h0D) begin
      bad++; $display("FAIL mid_cr got=%h want=0d", data);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; addr = 4'd0; bits_in = '0;
    test_reset();
    test_reversal();
    test_mixed();
    test_out_of_range();
    test_live_update();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
